// File: rtl/camerax_seq_if.sv
// Handshake bundle for camerax_seq: frame control, camera-x ROM port and column stream.
interface camerax_seq_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [8:0]  rom_addr;
  logic [15:0] rom_data;
  logic        col_valid;
  logic        col_ready;
  logic [8:0]  col_x;
  logic [15:0] col_camerax;

  modport master (
    input  start, rom_data, col_ready,
    output busy, done, rom_addr, col_valid, col_x, col_camerax
  );

  modport slave (
    output start, rom_data, col_ready,
    input  busy, done, rom_addr, col_valid, col_x, col_camerax
  );
endinterface

// File: rtl/camerax_seq.sv
// Streams camera-x ROM words for columns 0..NUM_COLS-1 through a 2-entry output FIFO.
// Optional abort input enabled by defining CAMERAX_SEQ_ABORT_EN.
module camerax_seq #(
  parameter int unsigned NUM_COLS = 320
) (
  input  logic           clk,
  input  logic           rst,
`ifdef CAMERAX_SEQ_ABORT_EN
  input  logic           abort,
`endif
  camerax_seq_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  localparam logic [8:0] LastCol = 9'(NUM_COLS - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q;
  logic [8:0]  last_q;
  logic        inflight_q;
  logic [8:0]  tag_q;
  logic [8:0]  mem_x_q [2];
  logic [15:0] mem_d_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  occ_q;
  logic        done_q, done_d;

  logic        pop, issue, kill, last_col;
  logic [2:0]  pending;

  always_comb begin
    pop      = (occ_q != 2'd0) && bus.col_ready;
`ifdef CAMERAX_SEQ_ABORT_EN
    kill     = abort && (state_q != StIdle);
`else
    kill     = 1'b0;
`endif
    // Credit counts the word leaving this cycle so a held col_ready streams one per cycle.
    pending  = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, pop};
    issue    = (state_q == StRun) && (pending < 3'd2) && !kill;
    last_col = pop && (mem_x_q[rd_ptr_q] == LastCol);

    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (issue && (cnt_q == LastCol)) state_d = StDrain;
      StDrain: if (last_col) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (kill) state_d = StIdle;

    done_d = (state_q == StDrain) && last_col && !kill;

    bus.rom_addr    = issue ? cnt_q : last_q;
    bus.busy        = (state_q != StIdle);
    bus.done        = done_q;
    bus.col_valid   = (occ_q != 2'd0);
    bus.col_x       = mem_x_q[rd_ptr_q];
    bus.col_camerax = mem_d_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      cnt_q      <= 9'd0;
      last_q     <= 9'd0;
      inflight_q <= 1'b0;
      tag_q      <= 9'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_x_q[i] <= 9'd0;
        mem_d_q[i] <= 16'd0;
      end
    end else begin
      state_q <= state_d;
      done_q  <= done_d;

      if ((state_q == StIdle) && bus.start) cnt_q <= 9'd0;
      else if (issue)                       cnt_q <= cnt_q + 9'd1;

      if (issue) last_q <= cnt_q;

      if (kill) begin
        inflight_q <= 1'b0;
        wr_ptr_q   <= 1'b0;
        rd_ptr_q   <= 1'b0;
        occ_q      <= 2'd0;
      end else begin
        inflight_q <= issue;
        tag_q      <= cnt_q;
        // The registered ROM answers the address issued last cycle.
        if (inflight_q) begin
          mem_x_q[wr_ptr_q] <= tag_q;
          mem_d_q[wr_ptr_q] <= bus.rom_data;
          wr_ptr_q          <= ~wr_ptr_q;
        end
        if (pop) rd_ptr_q <= ~rd_ptr_q;
        occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_camerax_seq.sv
// Directed self-checking bench for camerax_seq with a registered ROM model.
module tb_camerax_seq;

  localparam int NCOLS = 320;

  logic clk;
  logic rst;
  logic abort;
  int   checks;
  int   errors;

  camerax_seq_if bus ();

  camerax_seq #(.NUM_COLS(NCOLS)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef CAMERAX_SEQ_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input logic [8:0] a);
    return 16'(a) * 16'd149 + 16'h0a3c;
  endfunction

  always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic cycle(input logic rdy, input logic st, input logic kr, input logic ka);
    @(posedge clk);
    #1;
    bus.col_ready = rdy;
    bus.start     = st;
    rst           = kr;
    abort         = ka;
    #1;
  endtask

  // mode: 0 ready, 1 stall 5 cycles at column 100, 2 random ready, 3 start re-pulse at 50.
  // kill_kind: 0 none, 1 rst at kill_col, 2 abort at kill_col.
  task automatic run_frame(input string name, input int mode, input int kill_kind,
                           input int kill_col, input bit pre_started, input bit chain_next);
    int   exp_x, dones, first_v, first_t, last_t, stall_n;
    bit   bound_ok, stall_ok, restarted, killed, fin, busy_at_done, quiet;
    logic rdy, st, kr, ka;
    exp_x = 0; dones = 0; first_v = -1; first_t = -1; last_t = -1; stall_n = 0;
    bound_ok = 1'b1; stall_ok = 1'b1; restarted = 1'b0; killed = 1'b0; fin = 1'b0;
    busy_at_done = 1'b1;
    if (!pre_started) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int c = 1; c < 3000 && !fin && !killed; c++) begin
      rdy = 1'b1; st = 1'b0; kr = 1'b0; ka = 1'b0;
      if (mode == 1 && exp_x == 100 && stall_n < 5) begin rdy = 1'b0; stall_n++; end
      if (mode == 2) rdy = 1'($urandom_range(0, 1));
      if (mode == 3 && exp_x == 50 && !restarted) begin st = 1'b1; restarted = 1'b1; end
      if (kill_kind != 0 && exp_x == kill_col) begin
        kr = (kill_kind == 1); ka = (kill_kind == 2); killed = 1'b1;
      end
      cycle(rdy, st, kr, ka);
      if (bus.col_valid && first_v < 0) first_v = c;
      if (bus.done) begin
        dones++; fin = 1'b1; busy_at_done = bus.busy;
        if (chain_next) bus.start = 1'b1;
      end
      if (mode == 1 && !rdy && !(bus.col_valid && bus.col_x == 9'd100)) stall_ok = 1'b0;
      if (bus.busy && int'(bus.rom_addr) > exp_x + 1 + int'(bus.col_valid && rdy))
        bound_ok = 1'b0;
      if (!killed && bus.col_valid && rdy) begin
        chk({name, "_col_x"}, 32'(bus.col_x), 32'(exp_x));
        chk({name, "_camerax"}, 32'(bus.col_camerax), 32'(rom_fn(9'(exp_x))));
        if (first_t < 0) first_t = c;
        last_t = c;
        exp_x++;
      end
    end
    chk({name, "_first_valid_cycle"}, 32'(first_v), 32'd3);
    chk({name, "_fifo_bound"}, 32'(bound_ok), 32'd1);
    if (kill_kind == 0) begin
      chk({name, "_done_seen"}, 32'(fin), 32'd1);
      chk({name, "_done_count"}, 32'(dones), 32'd1);
      chk({name, "_transfers"}, 32'(exp_x), 32'(NCOLS));
      chk({name, "_busy_in_done"}, 32'(busy_at_done), 32'd0);
      if (mode == 0) chk({name, "_back_to_back"}, 32'(last_t - first_t), 32'(NCOLS - 1));
      if (mode == 1) begin
        chk({name, "_stall_stable"}, 32'(stall_ok), 32'd1);
        chk({name, "_stall_len"}, 32'(stall_n), 32'd5);
      end
      if (!chain_next) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk({name, "_done_pulse_end"}, 32'(bus.done), 32'd0);
        chk({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
        chk({name, "_idle_valid"}, 32'(bus.col_valid), 32'd0);
      end
    end else begin
      chk({name, "_kill_transfers"}, 32'(exp_x), 32'(kill_col));
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      chk({name, "_kill_valid"}, 32'(bus.col_valid), 32'd0);
      chk({name, "_kill_busy"}, 32'(bus.busy), 32'd0);
      chk({name, "_kill_done"}, 32'(bus.done), 32'd0);
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        if (bus.done || bus.col_valid || bus.busy) quiet = 1'b0;
      end
      chk({name, "_kill_quiet"}, 32'(quiet), 32'd1);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; abort = 1'b0;
    bus.start = 1'b0; bus.col_ready = 1'b0;
    repeat (3) @(posedge clk);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_valid", 32'(bus.col_valid), 32'd0);
    chk("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("reset_col_x", 32'(bus.col_x), 32'd0);
    chk("reset_camerax", 32'(bus.col_camerax), 32'd0);

    run_frame("full", 0, 0, 0, 1'b0, 1'b1);
    run_frame("stall", 1, 0, 0, 1'b1, 1'b0);
    run_frame("random", 2, 0, 0, 1'b0, 1'b0);
    run_frame("restart", 3, 0, 0, 1'b0, 1'b0);
    run_frame("rst200", 0, 1, 200, 1'b0, 1'b0);
    run_frame("after_rst", 0, 0, 0, 1'b0, 1'b0);
`ifdef CAMERAX_SEQ_ABORT_EN
    run_frame("abort10", 0, 2, 10, 1'b0, 1'b0);
    run_frame("after_abort", 0, 0, 0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camerax_seq.md
CAMERAX_SEQ -- requirements
Module: camerax_seq

Interface
REQ-001 SHALL have parameter NUM_COLS, default 320, meaning columns per frame (1..512).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1, frame request pulse.
REQ-005 SHALL have port busy, output, 1, high from the accepted start until done.
REQ-006 SHALL have port done, output, 1, one-cycle pulse at frame end.
REQ-007 SHALL have port rom_addr, output, 9, column address to the camera-x ROM.
REQ-008 SHALL have port rom_data, input, 16, Q8.8 ROM word, valid one cycle after rom_addr (registered ROM).
REQ-009 SHALL have port col_valid, output, 1, a column sample is offered downstream.
REQ-010 SHALL have port col_ready, input, 1, downstream accepts; transfer = col_valid & col_ready at an edge.
REQ-011 SHALL have port col_x, output, 9, column index of the offered sample.
REQ-012 SHALL have port col_camerax, output, 16, Q8.8 camera-x of the offered sample, bit-exact copy of rom_data.

Function
REQ-013 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN on start while IDLE; RUN->DRAIN after address NUM_COLS-1 is issued; DRAIN->IDLE on the transfer of column NUM_COLS-1.
REQ-014 SHALL ignore start while busy.
REQ-015 SHALL issue addresses 0..NUM_COLS-1 in ascending order, each exactly once per frame.
REQ-016 SHALL hold a 2-entry output FIFO and issue a new address only when (FIFO occupancy + words in flight) < 2.
REQ-017 SHALL write rom_data into the FIFO on the edge ending the cycle after its address was driven, tagged with its address as col_x.
REQ-018 SHALL present the FIFO head on col_x/col_camerax with col_valid = FIFO non-empty; outputs stable while col_valid & !col_ready.
REQ-019 SHALL assert first col_valid in the cycle after the third edge following (and counting) the edge that sampled start.
REQ-020 SHALL sustain one transfer per cycle while col_ready is held high.
REQ-021 SHALL support simultaneous FIFO write and read in one cycle without loss or reordering.
REQ-022 SHALL pulse done for exactly one cycle, the cycle after the edge transferring column NUM_COLS-1, with busy low in that same cycle.
REQ-023 SHALL accept a new start in the done cycle.
REQ-024 SHALL hold rom_addr at the last issued address when not issuing (0 after reset).

Reset
REQ-025 SHALL on rst force state IDLE, busy=0, done=0, col_valid=0, rom_addr=0, col_x=0, col_camerax=0, FIFO empty, in-flight cleared.
REQ-026 SHALL on rst mid-frame discard all pending words, and emit no done and no col_valid until a new start.

Configuration
REQ-027 SHALL, with CAMERAX_SEQ_ABORT_EN defined, add input abort (1 bit); abort high at an edge with busy forces IDLE, flushes FIFO and in-flight, no done pulse; abort has priority over a same-cycle transfer.
REQ-028 SHALL, without CAMERAX_SEQ_ABORT_EN, have no abort port; a frame ends only by completion or rst.

Verification
REQ-029 SHALL test: start pulse, col_ready=1 -> 320 transfers, col_x 0..319 on consecutive cycles, camerax equals ROM model, one done pulse.
REQ-030 SHALL test: col_ready low 5 cycles at column 100 -> col_x=100 held stable, sequence resumes 100,101,... with no drop or duplicate.
REQ-031 SHALL test: random col_ready (50%) full frame -> exactly 320 in-order transfers, FIFO never exceeds 2.
REQ-032 SHALL test: start re-pulsed at column 50 -> ignored, single done after column 319.
REQ-033 SHALL test: rst at column 200 -> next cycle col_valid=0, busy=0, no done; new start restarts at col_x=0.
REQ-034 SHALL test (CAMERAX_SEQ_ABORT_EN): abort at column 10 with col_ready=1 -> IDLE next cycle, no done, new start yields col_x=0.
